// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 types, constants and sigma helpers
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int SCHED_LEN       = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  function automatic word_t sigma0(word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic word_t bswap32(word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block-in / schedule-word-out handshake bundle
interface sha256_msg_schedule_if;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_valid;
  logic         w_last;
  logic         w_ready;

  modport master (
    output block_in, block_valid, w_ready,
    input  block_ready, w_data, w_idx, w_valid, w_last
  );

  modport slave (
    input  block_in, block_valid, w_ready,
    output block_ready, w_data, w_idx, w_valid, w_last
  );
endinterface

// File: rtl/sha256_sched_word.sv
// rtl/sha256_sched_word.sv - combinational W[t+16] from the sliding window
module sha256_sched_word
  import sha256_pkg::*;
(
  input  word_t w14,
  input  word_t w9,
  input  word_t w1,
  input  word_t w0,
  output word_t w_next
);

  assign w_next = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule; SHA256_SCHED_BYTESWAP_EN byte-reverses loaded words
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  sha256_msg_schedule_if.slave        bus
);

  sched_state_t state_q, state_d;
  logic [5:0]   t_q, t_d;
  word_t        window_q [WORDS_PER_BLOCK];
  word_t        window_d [WORDS_PER_BLOCK];
  word_t        w_next;

  function automatic word_t load_word(word_t x);
`ifdef SHA256_SCHED_BYTESWAP_EN
    return bswap32(x);
`else
    return x;
`endif
  endfunction

  sha256_sched_word u_word (
    .w14    (window_q[14]),
    .w9     (window_q[9]),
    .w1     (window_q[1]),
    .w0     (window_q[0]),
    .w_next (w_next)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (bus.block_valid) begin
          for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            window_d[i] = load_word(bus.block_in[511-32*i -: 32]);
          end
          t_d     = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.w_ready) begin
          for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) begin
            window_d[i] = window_q[i+1];
          end
          window_d[WORDS_PER_BLOCK-1] = w_next;
          // t wraps to 0 after the last word, which is also the idle value
          t_d = t_q + 6'd1;
          if (t_q == 6'(SCHED_LEN - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        window_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      window_q <= window_d;
    end
  end

  assign bus.block_ready = (state_q == IDLE);
  assign bus.w_valid     = (state_q == RUN);
  assign bus.w_data      = window_q[0];
  assign bus.w_idx       = t_q;
  assign bus.w_last      = (state_q == RUN) && (t_q == 6'(SCHED_LEN - 1));

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench with random blocks and stalls
module tb_sha256_msg_schedule;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  sha256_msg_schedule_if bus ();

  sha256_msg_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks;
  int           failures;
  int           cyc;
  exp_t         exp_q [$];
  logic [511:0] blk_q [$];
  logic [31:0]  got [64];
  bit           stall_en;

  logic [511:0] abc_blk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: textbook W[t] recurrence over a full 64-entry array
  task automatic push_expected(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      w[i] = blk[511-32*i -: 32];
`ifdef SHA256_SCHED_BYTESWAP_EN
      w[i] = {w[i][7:0], w[i][15:8], w[i][23:16], w[i][31:24]};
`endif
    end
    for (int i = 16; i < 64; i++) begin
      w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      e.d    = w[i];
      e.idx  = 6'(i);
      e.last = (i == 63);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.w_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every word handshake
  initial begin
    bit          prev_stall;
    bit          prev_last_hs;
    bit          prev_valid;
    bit          gap_armed;
    logic [31:0] prev_data;
    logic [5:0]  prev_idx;
    int          last_hs_cyc;
    exp_t        e;
    prev_stall = 0; prev_last_hs = 0; prev_valid = 0; gap_armed = 0;
    prev_data = '0; prev_idx = '0; last_hs_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; prev_last_hs = 0; prev_valid = 0; gap_armed = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(bus.w_valid), 64'd1);
          chk("stall_data", 64'(bus.w_data), 64'(prev_data));
          chk("stall_idx", 64'(bus.w_idx), 64'(prev_idx));
        end
        if (prev_last_hs) chk("ready_after_last", 64'(bus.block_ready), 64'd1);
        if (gap_armed && bus.w_valid && !prev_valid) begin
          chk("b2b_gap", 64'(cyc - last_hs_cyc), 64'd2);
          gap_armed = 0;
        end
        if (bus.w_valid) chk("ready_low_in_run", 64'(bus.block_ready), 64'd0);
        if (!bus.w_valid) chk("last_without_valid", 64'(bus.w_last), 64'd0);
        prev_last_hs = 0;
        if (bus.w_valid && bus.w_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(bus.w_idx), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("w_data", 64'(bus.w_data), 64'(e.d));
            chk("w_idx", 64'(bus.w_idx), 64'(e.idx));
            chk("w_last", 64'(bus.w_last), 64'(e.last));
          end
          got[bus.w_idx] = bus.w_data;
          if (bus.w_last) begin
            prev_last_hs = 1;
            last_hs_cyc  = cyc;
            if (bus.block_valid) gap_armed = 1;
          end
        end
        prev_stall = bus.w_valid && !bus.w_ready;
        prev_data  = bus.w_data;
        prev_idx   = bus.w_idx;
        prev_valid = bus.w_valid;
      end
    end
  end

  // Holds block_valid high across the whole queue, so blocks go back-to-back
  task automatic drive_blocks();
    int guard;
    while (blk_q.size() > 0) begin
      @(posedge clk);
      #1;
      bus.block_in    = blk_q[0];
      bus.block_valid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!bus.block_ready && guard < 400);
      if (!bus.block_ready) begin
        chk("block_accept_timeout", 64'd0, 64'd1);
        blk_q.delete();
      end else begin
        push_expected(blk_q[0]);
        void'(blk_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    bus.block_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && bus.block_ready) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_block_ready"}, 64'(bus.block_ready), 64'd1);
    chk({tag, "_w_valid"}, 64'(bus.w_valid), 64'd0);
    chk({tag, "_w_last"}, 64'(bus.w_last), 64'd0);
    chk({tag, "_w_idx"}, 64'(bus.w_idx), 64'd0);
    chk({tag, "_w_data"}, 64'(bus.w_data), 64'd0);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction

  initial begin
    int guard;
    checks = 0; failures = 0; stall_en = 0;
`ifdef SHA256_SCHED_BYTESWAP_EN
    abc_blk = {32'h80636261, 448'h0, 32'h18000000};
`else
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
`endif
    rst_n = 1'b0;
    bus.block_valid = 1'b0;
    bus.block_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    blk_q.push_back(abc_blk);
    drive_blocks();
    wait_idle();
    chk("abc_w0", 64'(got[0]), 64'h61626380);
    chk("abc_w15", 64'(got[15]), 64'h00000018);
    chk("abc_w16", 64'(got[16]), 64'h61626380);
    chk("abc_w17", 64'(got[17]), 64'h000F0000);

    stall_en = 1;
    got[17] = '0;
    blk_q.push_back(abc_blk);
    drive_blocks();
    wait_idle();
    chk("abc_stall_w17", 64'(got[17]), 64'h000F0000);

    for (int i = 0; i < 3; i++) blk_q.push_back(rand_block());
    drive_blocks();
    wait_idle();

    stall_en = 0;
    blk_q.push_back(abc_blk);
    blk_q.push_back(rand_block());
    drive_blocks();
    wait_idle();

    blk_q.push_back(abc_blk);
    drive_blocks();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(bus.w_valid && bus.w_idx == 6'd30) && guard < 200);
    chk("reach_t30", 64'(bus.w_idx), 64'd30);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    blk_q.push_back(rand_block());
    drive_blocks();
    wait_idle();

    blk_q.push_back(rand_block());
    drive_blocks();
    repeat (5) @(posedge clk);
    #1;
    bus.block_in    = rand_block();
    bus.block_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.block_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("no_extra_block", 64'(bus.w_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
